// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory read ports, redirect, and the decode-side
// window onto the fetch queue head.
interface fetch_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0]         Program_counter_IF_Pipeline_0;
  logic [WIDTH-1:0]         Program_counter_IF_Pipeline_1;
  logic [WIDTH-1:0]         Instruction_IF_Pipeline_0;
  logic [WIDTH-1:0]         Instruction_IF_Pipeline_1;
  logic                     redirect_valid;
  logic [WIDTH-1:0]         redirect_pc;
  logic [1:0]               deq_count;
  logic                     out_valid_0;
  logic                     out_valid_1;
  logic [WIDTH-1:0]         out_instr_0;
  logic [WIDTH-1:0]         out_instr_1;
  logic [WIDTH-1:0]         out_pc_0;
  logic [WIDTH-1:0]         out_pc_1;
  logic [$clog2(DEPTH):0]   occupancy;

  // Handshake: out_valid_k marks head+k as holding a real entry; decode takes
  // deq_count entries on the clock edge and must not exceed the asserted valids
  // (an over-request is clamped to count). redirect_valid wins over both.
  modport master (
    output Program_counter_IF_Pipeline_0, Program_counter_IF_Pipeline_1,
    input  Instruction_IF_Pipeline_0, Instruction_IF_Pipeline_1,
    input  redirect_valid, redirect_pc, deq_count,
    output out_valid_0, out_valid_1, out_instr_0, out_instr_1,
    output out_pc_0, out_pc_1, occupancy
  );

  modport slave (
    input  Program_counter_IF_Pipeline_0, Program_counter_IF_Pipeline_1,
    output Instruction_IF_Pipeline_0, Instruction_IF_Pipeline_1,
    output redirect_valid, redirect_pc, deq_count,
    input  out_valid_0, out_valid_1, out_instr_0, out_instr_1,
    input  out_pc_0, out_pc_1, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue fetch stage: owns fetch_pc, reads two sequential instructions per
// cycle and buffers them with their PCs in a circular queue drained by decode.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [WIDTH-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic [CW-1:0]    free;
  logic [1:0]       enq;
  logic [1:0]       req;
  logic [1:0]       eff;
  logic [PW-1:0]    head_p1;
  logic [PW-1:0]    tail_p1;

  // Enqueue depends only on the registered count, never on deq_count, which
  // keeps decode off the fetch timing path (costs a bubble when full).
  always_comb begin
    free    = CW'(DEPTH) - count;
    enq     = 2'd0;
    if (free >= CW'(2))      enq = 2'd2;
    else if (free == CW'(1)) enq = 2'd1;
    req     = (bus.deq_count == 2'd3) ? 2'd2 : bus.deq_count;
    eff     = (CW'(req) > count) ? count[1:0] : req;
    head_p1 = head + PW'(1);
    tail_p1 = tail + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~WIDTH'(3);
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq != 2'd0) begin
        mem_instr[tail] <= bus.Instruction_IF_Pipeline_0;
        mem_pc[tail]    <= fetch_pc;
      end
      if (enq == 2'd2) begin
        mem_instr[tail_p1] <= bus.Instruction_IF_Pipeline_1;
        mem_pc[tail_p1]    <= fetch_pc + WIDTH'(4);
      end
      tail     <= tail + PW'(enq);
      fetch_pc <= fetch_pc + (WIDTH'(enq) << 2);
      head     <= head + PW'(eff);
      count    <= count + CW'(enq) - CW'(eff);
    end
  end

  assign bus.Program_counter_IF_Pipeline_0 = fetch_pc;
  assign bus.Program_counter_IF_Pipeline_1 = fetch_pc + WIDTH'(4);
  assign bus.out_valid_0 = (count >= CW'(1));
  assign bus.out_valid_1 = (count >= CW'(2));
  assign bus.out_instr_0 = mem_instr[head];
  assign bus.out_instr_1 = mem_instr[head_p1];
  assign bus.out_pc_0    = mem_pc[head];
  assign bus.out_pc_1    = mem_pc[head_p1];
  assign bus.occupancy   = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the fetch buffer.
module tb_fetch_queue;
  localparam int          W        = 32;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fetch_queue_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.WIDTH(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Instruction memory: word i holds 32'h1000_0000 + i.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction
  assign bus.Instruction_IF_Pipeline_0 = mem_word(bus.Program_counter_IF_Pipeline_0);
  assign bus.Instruction_IF_Pipeline_1 = mem_word(bus.Program_counter_IF_Pipeline_1);

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds {pc, instr} of every entry the queue should hold, head first.
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_pc = '0;
  logic           model_live = 1'b0;

  always @(posedge clk) begin
    int free, n, take;
    if (rst) begin
      exp_q.delete();
      model_pc   = RESET_PC;
      model_live = 1'b1;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      model_pc = {bus.redirect_pc[W-1:2], 2'b00};
    end else if (model_live) begin
      free = DEPTH - exp_q.size();
      n    = (free >= 2) ? 2 : free;
      take = (bus.deq_count == 2'd3) ? 2 : int'(bus.deq_count);
      if (take > exp_q.size()) take = exp_q.size();
      for (int k = 0; k < take; k++) void'(exp_q.pop_front());
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({model_pc, mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare everything the DUT presents mid-cycle against the model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("mon_occupancy", W'(bus.occupancy), W'(exp_q.size()));
      chk("mon_valid_0", W'(bus.out_valid_0), W'(exp_q.size() >= 1));
      chk("mon_valid_1", W'(bus.out_valid_1), W'(exp_q.size() >= 2));
      chk("mon_fetch_pc_0", bus.Program_counter_IF_Pipeline_0, model_pc);
      chk("mon_fetch_pc_1", bus.Program_counter_IF_Pipeline_1, model_pc + 32'd4);
      if (exp_q.size() >= 1) begin
        chk("mon_out_pc_0", bus.out_pc_0, exp_q[0][2*W-1:W]);
        chk("mon_out_instr_0", bus.out_instr_0, exp_q[0][W-1:0]);
      end
      if (exp_q.size() >= 2) begin
        chk("mon_out_pc_1", bus.out_pc_1, exp_q[1][2*W-1:W]);
        chk("mon_out_instr_1", bus.out_instr_1, exp_q[1][W-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs; returns just after the edge that consumes them.
  task automatic step(input logic r, input logic rv, input logic [W-1:0] rpc,
                      input logic [1:0] dq);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.deq_count      = dq;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] exp_head;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.deq_count      = 2'd0;

    // Reset values
    step(1'b1, 1'b0, '0, 2'd0);
    step(1'b1, 1'b0, '0, 2'd0);
    chk("rst_fetch_pc_0", bus.Program_counter_IF_Pipeline_0, RESET_PC);
    chk("rst_fetch_pc_1", bus.Program_counter_IF_Pipeline_1, RESET_PC + 32'd4);
    chk("rst_occupancy", W'(bus.occupancy), 32'd0);
    chk("rst_valids", {30'd0, bus.out_valid_1, bus.out_valid_0}, 32'd0);
    chk("rst_out_pc_0", bus.out_pc_0, 32'd0);
    chk("rst_out_instr_0", bus.out_instr_0, 32'd0);

    // Fill with no dequeue
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 2'd0);
    chk("fill_occupancy", W'(bus.occupancy), 32'd8);
    chk("fill_head_pc_0", bus.out_pc_0, 32'h0);
    chk("fill_head_pc_1", bus.out_pc_1, 32'h4);
    chk("fill_head_instr_1", bus.out_instr_1, 32'h1000_0001);
    chk("fill_stall_pc", bus.Program_counter_IF_Pipeline_0, 32'h20);
    step(1'b0, 1'b0, '0, 2'd0);
    chk("fill_hold_pc", bus.Program_counter_IF_Pipeline_0, 32'h20);
    chk("fill_hold_occ", W'(bus.occupancy), 32'd8);

    // Odd free slot: pop one (no enqueue while full), then a single enqueue
    step(1'b0, 1'b0, '0, 2'd1);
    chk("odd_occ_7", W'(bus.occupancy), 32'd7);
    chk("odd_pc_held", bus.Program_counter_IF_Pipeline_0, 32'h20);
    step(1'b0, 1'b0, '0, 2'd0);
    chk("odd_occ_8", W'(bus.occupancy), 32'd8);
    chk("odd_pc_plus4", bus.Program_counter_IF_Pipeline_0, 32'h24);

    // Streaming: bubble on the full cycle, then steady 2-in/2-out
    exp_head = 32'h4;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0, 2'd2);
      exp_head = exp_head + 32'd8;
      chk("stream_occ", W'(bus.occupancy), 32'd6);
      chk("stream_pc_0", bus.out_pc_0, exp_head);
      chk("stream_pc_1", bus.out_pc_1, exp_head + 32'd4);
    end

    // Redirect with simultaneous dequeue, misaligned target
    step(1'b0, 1'b1, 32'h0000_0103, 2'd2);
    chk("redir_occ", W'(bus.occupancy), 32'd0);
    chk("redir_valid_0", W'(bus.out_valid_0), 32'd0);
    chk("redir_fetch_pc", bus.Program_counter_IF_Pipeline_0, 32'h100);
    // Over-request at empty: clamped to zero
    step(1'b0, 1'b0, '0, 2'd3);
    chk("redir_out_pc_0", bus.out_pc_0, 32'h100);
    chk("redir_out_pc_1", bus.out_pc_1, 32'h104);
    chk("clamp_empty_occ", W'(bus.occupancy), 32'd2);
    step(1'b0, 1'b0, '0, 2'd0);
    chk("clamp_pre_occ", W'(bus.occupancy), 32'd4);
    step(1'b0, 1'b0, '0, 2'd3);
    chk("clamp_deq3_occ", W'(bus.occupancy), 32'd4);
    chk("clamp_deq3_head", bus.out_pc_0, 32'h108);
    step(1'b0, 1'b0, '0, 2'd1);
    chk("pre_reset_occ", W'(bus.occupancy), 32'd5);

    // Reset beats redirect
    step(1'b1, 1'b1, 32'h0000_0200, 2'd0);
    chk("rst_mid_fetch_pc", bus.Program_counter_IF_Pipeline_0, RESET_PC);
    chk("rst_mid_occ", W'(bus.occupancy), 32'd0);
    chk("rst_mid_valids", {30'd0, bus.out_valid_1, bus.out_valid_0}, 32'd0);
    chk("rst_mid_out_pc_0", bus.out_pc_0, 32'd0);

    // Random traffic, including rare redirects and resets
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) == 0),
           $urandom,
           2'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0, '0, 2'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
